// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshakes. Logic, add/sub and SLT finish in one cycle;
// shifts iterate one bit per cycle and stall the producer through in_ready.
module alu_exec_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             err
);

  typedef enum logic [1:0] {StIdle, StBusy, StHold} state_e;

  state_e           state;
  logic [WIDTH-1:0] sh_val;
  logic [SHW-1:0]   sh_cnt;
  logic             sh_left;
  logic             sh_arith;

  logic             accept;
  logic             is_shift;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_err;
  logic [WIDTH-1:0] sh_next;

  assign in_ready = (state == StIdle) || ((state == StHold) && out_ready);
  assign accept   = in_valid && in_ready;
  assign shamt    = op_b[SHW-1:0];
  assign is_shift = (alu_ctrl == 4'b0100) || (alu_ctrl == 4'b0101) || (alu_ctrl == 4'b1000);

  // Shift codes yield op_a here; only the zero-amount case uses this path.
  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    case (alu_ctrl)
      4'b0000: alu_res = op_a & op_b;
      4'b0001: alu_res = op_a | op_b;
      4'b0010: alu_res = op_a + op_b;
      4'b0110: alu_res = op_a - op_b;
      4'b0011: alu_res = op_a ^ op_b;
      4'b0111: alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      4'b0100, 4'b0101, 4'b1000: alu_res = op_a;
      default: alu_err = 1'b1;
    endcase
  end

  always_comb begin
    if (sh_left) sh_next = {sh_val[WIDTH-2:0], 1'b0};
    else         sh_next = {sh_arith & sh_val[WIDTH-1], sh_val[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      err       <= 1'b0;
      sh_val    <= '0;
      sh_cnt    <= '0;
      sh_left   <= 1'b0;
      sh_arith  <= 1'b0;
    end else begin
      case (state)
        StIdle, StHold: begin
          if (accept) begin
            if (is_shift && (shamt != '0)) begin
              sh_val    <= op_a;
              sh_cnt    <= shamt;
              sh_left   <= (alu_ctrl == 4'b0100);
              sh_arith  <= (alu_ctrl == 4'b1000);
              state     <= StBusy;
              out_valid <= 1'b0;
            end else begin
              result    <= alu_res;
              zero      <= (alu_res == '0);
              err       <= alu_err;
              state     <= StHold;
              out_valid <= 1'b1;
            end
          end else if ((state == StHold) && out_ready) begin
            state     <= StIdle;
            out_valid <= 1'b0;
          end
        end
        StBusy: begin
          sh_val <= sh_next;
          sh_cnt <= sh_cnt - 1'b1;
          if (sh_cnt == SHW'(1)) begin
            result    <= sh_next;
            zero      <= (sh_next == '0);
            err       <= 1'b0;
            state     <= StHold;
            out_valid <= 1'b1;
          end
        end
        default: begin
          state     <= StIdle;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed and randomized checks of alu_exec_unit against an arithmetic reference model.
module tb_alu_exec_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        err;

  int checks   = 0;
  int failures = 0;

  alu_exec_unit #(.WIDTH(32), .SHW(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: result, error flag and cycles from acceptance to out_valid.
  function automatic void ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic e, output int lat);
    int n;
    n   = int'(b % 32);
    e   = 1'b0;
    lat = 1;
    r   = 32'd0;
    case (c)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd2: r = a + b;
      4'd6: r = a - b;
      4'd3: r = a ^ b;
      4'd7: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4: begin r = a << n; lat = (n == 0) ? 1 : n + 1; end
      4'd5: begin r = a >> n; lat = (n == 0) ? 1 : n + 1; end
      4'd8: begin r = $unsigned($signed(a) >>> n); lat = (n == 0) ? 1 : n + 1; end
      default: e = 1'b1;
    endcase
  endfunction

  task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] got);
    logic [31:0] exp_r;
    logic        exp_e;
    int          exp_lat;
    int          lat;
    bit          done;
    ref_alu(c, a, b, exp_r, exp_e, exp_lat);
    @(negedge clk);
    out_ready = 1'b1;
    alu_ctrl  = c;
    op_a      = a;
    op_b      = b;
    in_valid  = 1'b1;
    check_eq("accept_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op_a     = $urandom;
    op_b     = $urandom;
    lat      = 0;
    done     = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid) done = 1'b1;
      else check_eq("busy_in_ready", 32'(in_ready), 32'd0);
    end
    check_eq("latency", 32'(lat), 32'(exp_lat));
    check_eq("result", result, exp_r);
    check_eq("zero", 32'(zero), 32'(exp_r == 32'd0));
    check_eq("err", 32'(err), 32'(exp_e));
    got = result;
  endtask

  logic [3:0]  bb_c [5] = '{4'd2, 4'd6, 4'd0, 4'd1, 4'd7};
  logic [31:0] bb_a [5] = '{32'd7, 32'd5, 32'h0000F0F0, 32'h0000F0F0, 32'hFFFFFFFF};
  logic [31:0] bb_b [5] = '{32'hFFFFFFF9, 32'd9, 32'h0000FF00, 32'h0000FF00, 32'd1};
  logic [31:0] bb_r [5] = '{32'd0, 32'hFFFFFFFC, 32'h0000F000, 32'h0000FFF0, 32'd1};

  initial begin
    logic [31:0] got;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    alu_ctrl  = 4'd0;
    op_a      = 32'd0;
    op_b      = 32'd0;
    #12;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_result", result, 32'd0);
    check_eq("rst_zero", 32'(zero), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset while shifting aborts the operation.
    @(negedge clk);
    alu_ctrl = 4'd4; op_a = 32'd1; op_b = 32'd20; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_result", result, 32'd0);
    check_eq("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(4'd2, 32'd2, 32'd3, got);
    check_eq("post_rst_add", got, 32'd5);

    // Back-to-back single-cycle ops, one result per cycle.
    for (int i = 0; i <= 5; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check_eq("b2b_valid", 32'(out_valid), 32'd1);
        check_eq("b2b_result", result, bb_r[i-1]);
        check_eq("b2b_zero", 32'(zero), 32'(i == 1));
      end
      if (i < 5) begin
        alu_ctrl = bb_c[i]; op_a = bb_a[i]; op_b = bb_b[i]; in_valid = 1'b1;
        check_eq("b2b_in_ready", 32'(in_ready), 32'd1);
      end else begin
        in_valid = 1'b0;
      end
    end

    run_op(4'd8, 32'h80000000, 32'd4, got);
    check_eq("sra_lit", got, 32'hF8000000);
    run_op(4'd5, 32'h80000000, 32'd4, got);
    check_eq("srl_lit", got, 32'h08000000);
    run_op(4'd4, 32'd1, 32'd31, got);
    check_eq("sll31_lit", got, 32'h80000000);
    run_op(4'd4, 32'h12345678, 32'd0, got);
    check_eq("sh0_lit", got, 32'h12345678);
    run_op(4'hF, 32'd9, 32'd9, got);
    check_eq("illegal_lit", got, 32'd0);
    run_op(4'd2, 32'd1, 32'd1, got);
    check_eq("after_illegal_lit", got, 32'd2);

    // Backpressure: result held, new input refused until out_ready rises.
    @(negedge clk);
    out_ready = 1'b0;
    alu_ctrl = 4'd2; op_a = 32'd3; op_b = 32'd4; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("bp_valid", 32'(out_valid), 32'd1);
      check_eq("bp_result", result, 32'd7);
      check_eq("bp_in_ready", 32'(in_ready), 32'd0);
      alu_ctrl = 4'd0; op_a = 32'hFFFF; op_b = 32'h00FF; in_valid = 1'b1;
    end
    @(negedge clk);
    check_eq("bp_still_held", result, 32'd7);
    alu_ctrl = 4'd6; op_a = 32'd9; op_b = 32'd2; out_ready = 1'b1;
    #1 check_eq("bp_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check_eq("bp_sub_valid", 32'(out_valid), 32'd1);
    check_eq("bp_sub_result", result, 32'd7);
    check_eq("bp_sub_err", 32'(err), 32'd0);

    // Randomized ops across all codes, including illegal ones.
    for (int k = 0; k < 200; k++) begin
      logic [3:0]  c;
      logic [31:0] a;
      logic [31:0] b;
      c = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'h80000000 | a;
      if ($urandom_range(0, 3) == 0) b = a;
      run_op(c, a, b, got);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Execute-stage ALU, directly downstream of the ALU-control decoder. It consumes the decoder's 4-bit ALU control code and two operands, computes the result, and returns it through a valid/ready handshake together with zero and error flags. Logic ops, add/sub and SLT complete in one cycle. Shifts run iteratively at one bit per cycle, so the block stalls its producer through in_ready.

Parameters:
WIDTH, 32, operand/result width in bits
SHW, 5, shift-amount width (log2 WIDTH)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operation presented
in_ready  output  1  unit can accept an operation this cycle
alu_ctrl  input  4  control code from the ALU-control decoder
op_a  input  WIDTH  operand A
op_b  input  WIDTH  operand B; shift amount is op_b[SHW-1:0]
out_valid  output  1  result/flags valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  registered result
zero  output  1  result == 0
err  output  1  illegal control code was executed

Behaviour:
- Reset: one clock; reset is asynchronous and active-low; ports named clk and rst_n. While rst_n=0: state=IDLE, out_valid=0, result=0, zero=0, err=0, shift registers=0. Reset during BUSY aborts the shift and drops the operation.
- Codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0011 XOR, 0111 SLT (signed, result 1 or 0), 0100 SLL, 0101 SRL, 1000 SRA. Every other code, including 1111 (decoder error), is illegal.
- ADD/SUB: modulo 2^WIDTH; no carry or overflow output.
- Illegal code: result=0, zero=1, err=1, latency 1. The unit continues operating normally.
- err=0 and zero=(result==0) for every legal op.
- Transfer occurs on in_valid&&in_ready. Output transfer occurs on out_valid&&out_ready.
- FSM states:
  - IDLE: no result pending; in_ready=1.
  - BUSY: shifting; in_ready=0, out_valid=0.
  - HOLD: result pending; out_valid=1; in_ready=out_ready.
- IDLE/HOLD with input accepted:
  - Non-shift op or shift amount 0: result registered at that edge; next state HOLD. Latency 1, so out_valid is high the following cycle.
  - Shift with amount N>0: latch op_a, N, direction and arithmetic flag; next state BUSY.
- HOLD, no new input, out_ready=1: next state IDLE, out_valid=0.
- HOLD, out_ready=0: result/zero/err held stable and in_ready=0. in_valid is ignored.
- BUSY: each cycle shift the working value by 1 bit (SRA replicates the MSB) and decrement the counter. When the counter reaches 1, write the final value to result and go to HOLD. A shift by N therefore has out_valid high N+1 cycles after acceptance. Max N = WIDTH-1.
- Back-to-back: in HOLD with out_ready=1 and in_valid=1, the old result drains and the new op is accepted in the same cycle. Throughput is 1 op/cycle for non-shift ops.
- Input operands need only be stable during the accept cycle.
- No combinational path from in_valid to out_valid. in_ready depends combinationally only on state and out_ready.

Test Plan:
- Reset mid-shift: accept SLL op_a=1 op_b=20, assert rst_n=0 at cycle 5 -> out_valid=0, result=0, state IDLE immediately; after release, ADD 2+3 -> result=5.
- Single-cycle ops, out_ready=1, back-to-back: ADD 7+(-7) -> result=0, zero=1; SUB 5-9 -> 0xFFFFFFFC; AND 0xF0F0&0xFF00 -> 0xF000; OR -> 0xFFF0; SLT -1<1 -> 1. Each result appears 1 cycle after acceptance, one per cycle.
- Shifts: SRA 0x80000000 by 4 -> 0xF8000000 after 5 cycles; SRL same -> 0x08000000; SLL 1 by 31 -> 0x80000000 after 32 cycles, in_ready=0 throughout; shift by 0 -> op_a unchanged, latency 1.
- Illegal code: alu_ctrl=1111 -> result=0, zero=1, err=1; next op ADD 1+1 -> result=2, err=0.
- Backpressure: out_ready=0 for 4 cycles after ADD 3+4 -> result=7 held stable, in_ready=0, a new in_valid is not accepted; raising out_ready with a SUB 9-2 presented -> 7 drains and SUB is accepted the same cycle, giving 7 next cycle.
